// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB requester block.
package apb_master_pkg;

    // APB address and data bus width.
    localparam int APB_DW = 32;

    // Width of the ACCESS-phase timeout counter.
    localparam int TMO_W = 16;

    // Requester FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase wait counter. Cleared on entry to ACCESS, counts cycles in
// which the completer holds PREADY low, and flags the increment that takes
// the count up to LIMIT so the requester can abort on that same edge.
module apb_timeout_counter
    import apb_master_pkg::*;
#(
    parameter int unsigned LIMIT = 16
)
(
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic inc,
    output logic limit_hit
);

    logic [TMO_W-1:0] count_reg;

    // Counter: reset and clear dominate, otherwise count stalled ACCESS cycles.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // This stalled cycle is the LIMIT-th one: the count reaches LIMIT now.
    assign limit_hit = inc && (count_reg == TMO_W'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into an APB SETUP/ACCESS
// transfer and returns a one-cycle response pulse.
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS after
// TIMEOUT_CYCLES stalled cycles (RSP_ERROR=1, RSP_RDATA=0).
module apb_master
    import apb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)
(
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [APB_DW-1:0] CMD_ADDR,
    input  logic [APB_DW-1:0] CMD_WDATA,
    output logic              RSP_VALID,
    output logic [APB_DW-1:0] RSP_RDATA,
    output logic              RSP_ERROR,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [APB_DW-1:0] PADDR,
    output logic [APB_DW-1:0] PWDATA,
    input  logic [APB_DW-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    // Reject out-of-range timeout limits at elaboration.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be within 1..65535");
    end

    apb_state_t        state_reg;
    logic              ready_reg;
    logic              psel_reg;
    logic              penable_reg;
    logic              pwrite_reg;
    logic [APB_DW-1:0] paddr_reg;
    logic [APB_DW-1:0] pwdata_reg;
    logic              rsp_valid_reg;
    logic [APB_DW-1:0] rsp_rdata_reg;
    logic              rsp_error_reg;
    logic              accept;
    logic              tmo_hit;

    // ready_reg is low for the first cycle after reset; the PRESET gate keeps
    // the handshake closed during the reset cycle itself.
    assign CMD_READY = ready_reg & ~PRESET;
    assign accept    = CMD_VALID & CMD_READY;

`ifdef APB_TIMEOUT_EN
    logic tmo_clear;
    logic tmo_inc;

    assign tmo_clear = (state_reg == SETUP);
    assign tmo_inc   = (state_reg == ACCESS) && !PREADY;

    apb_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (PCLK),
        .srst      (PRESET),
        .clear     (tmo_clear),
        .inc       (tmo_inc),
        .limit_hit (tmo_hit)
    );
`else
    assign tmo_hit = 1'b0;
`endif

    // Requester FSM with all outputs registered.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_reg     <= IDLE;
            ready_reg     <= 1'b0;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_error_reg <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b1;
                    if (accept) begin
                        ready_reg   <= 1'b0;
                        psel_reg    <= 1'b1;
                        penable_reg <= 1'b0;
                        pwrite_reg  <= CMD_WRITE;
                        paddr_reg   <= CMD_ADDR;
                        pwdata_reg  <= CMD_WDATA;
                        state_reg   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_reg <= 1'b1;
                    state_reg   <= ACCESS;
                end
                ACCESS: begin
                    // A completion in the limit cycle wins over the timeout.
                    if (PREADY) begin
                        psel_reg      <= 1'b0;
                        penable_reg   <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_error_reg <= PSLVERR;
                        rsp_rdata_reg <= pwrite_reg ? '0 : PRDATA;
                        ready_reg     <= 1'b1;
                        state_reg     <= IDLE;
                    end else if (tmo_hit) begin
                        psel_reg      <= 1'b0;
                        penable_reg   <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_error_reg <= 1'b1;
                        rsp_rdata_reg <= '0;
                        ready_reg     <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    psel_reg    <= 1'b0;
                    penable_reg <= 1'b0;
                    ready_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign PSELx     = psel_reg;
    assign PENABLE   = penable_reg;
    assign PWRITE    = pwrite_reg;
    assign PADDR     = paddr_reg;
    assign PWDATA    = pwdata_reg;
    assign RSP_VALID = rsp_valid_reg;
    assign RSP_RDATA = rsp_rdata_reg;
    assign RSP_ERROR = rsp_error_reg;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed and randomized transfers
// against a transaction-level expectation (latency, response data, APB
// phase values), plus reset-abort and back-to-back scenarios.
module tb_apb_master;

    localparam int TMO = 16;

    logic        PCLK      = 1'b0;
    logic        PRESET    = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_WRITE = 1'b0;
    logic [31:0] CMD_ADDR  = '0;
    logic [31:0] CMD_WDATA = '0;
    logic [31:0] PRDATA    = '0;
    logic        PREADY    = 1'b0;
    logic        PSLVERR   = 1'b0;
    logic        CMD_READY;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERROR;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    apb_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_WRITE (CMD_WRITE),
        .CMD_ADDR  (CMD_ADDR),
        .CMD_WDATA (CMD_WDATA),
        .RSP_VALID (RSP_VALID),
        .RSP_RDATA (RSP_RDATA),
        .RSP_ERROR (RSP_ERROR),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transfer. hang=1: completer never raises PREADY.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rdata, input logic err,
                        input logic hang);
        int          acc_cyc;
        int          n;
        int          access_cycles;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
        // Expected outcome of the transaction.
        if (hang) begin
            access_cycles = TMO;
            exp_rdata     = 32'h0;
            exp_err       = 1'b1;
        end else begin
            access_cycles = waits + 1;
            exp_rdata     = wr ? 32'h0 : rdata;
            exp_err       = err;
        end
        exp_lat = 2 + access_cycles;

        CMD_VALID = 1'b1;
        CMD_WRITE = wr;
        CMD_ADDR  = addr;
        CMD_WDATA = wdata;
        PREADY    = 1'b0;
        n = 0;
        while (CMD_READY !== 1'b1 && n < 8) begin
            @(negedge PCLK);
            n++;
        end
        chk("cmd_ready", {31'b0, CMD_READY}, 32'd1);
        acc_cyc = cyc;

        @(negedge PCLK);
        CMD_VALID = 1'b0;
        CMD_WRITE = 1'($urandom);
        CMD_ADDR  = $urandom;
        CMD_WDATA = $urandom;
        chk("setup_psel", {31'b0, PSELx}, 32'd1);
        chk("setup_penable", {31'b0, PENABLE}, 32'd0);
        chk("setup_paddr", PADDR, addr);
        chk("setup_pwdata", PWDATA, wdata);
        chk("setup_pwrite", {31'b0, PWRITE}, {31'b0, wr});

        for (int i = 0; i < access_cycles; i++) begin
            @(negedge PCLK);
            chk("access_psel", {31'b0, PSELx}, 32'd1);
            chk("access_penable", {31'b0, PENABLE}, 32'd1);
            chk("access_paddr", PADDR, addr);
            chk("access_pwrite", {31'b0, PWRITE}, {31'b0, wr});
            chk("access_no_rsp", {31'b0, RSP_VALID}, 32'd0);
            PREADY  = !hang && (i == waits);
            PRDATA  = PREADY ? rdata : $urandom;
            PSLVERR = PREADY ? err : 1'($urandom);
        end

        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (RSP_VALID !== 1'b1 && n < 40);
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        chk("rsp_valid", {31'b0, RSP_VALID}, 32'd1);
        chk("rsp_latency", cyc - acc_cyc, exp_lat);
        chk("rsp_error", {31'b0, RSP_ERROR}, {31'b0, exp_err});
        chk("rsp_rdata", RSP_RDATA, exp_rdata);
        chk("rsp_psel_low", {31'b0, PSELx}, 32'd0);
        chk("rsp_penable_low", {31'b0, PENABLE}, 32'd0);
        chk("rsp_cmd_ready", {31'b0, CMD_READY}, 32'd1);

        @(negedge PCLK);
        chk("rsp_pulse", {31'b0, RSP_VALID}, 32'd0);
        chk("rsp_rdata_hold", RSP_RDATA, exp_rdata);
        chk("rsp_error_hold", {31'b0, RSP_ERROR}, {31'b0, exp_err});
        chk("idle_paddr_hold", PADDR, addr);
        $display("xfer wr=%0d addr=%h waits=%0d hang=%0d -> rdata=%h err=%0d",
                 wr, addr, waits, hang, RSP_RDATA, RSP_ERROR);
    endtask

    initial begin
        int          acc1;
        int          acc2;
        int          n;
        logic        r_wr;
        logic [31:0] r_addr;
        logic [31:0] r_wdata;
        logic [31:0] r_rdata;
        logic        r_err;
        int          r_waits;

        // Reset values.
        repeat (3) @(negedge PCLK);
        chk("rst_cmd_ready", {31'b0, CMD_READY}, 32'd0);
        chk("rst_psel", {31'b0, PSELx}, 32'd0);
        chk("rst_penable", {31'b0, PENABLE}, 32'd0);
        chk("rst_pwrite", {31'b0, PWRITE}, 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_rsp_valid", {31'b0, RSP_VALID}, 32'd0);
        chk("rst_rsp_rdata", RSP_RDATA, 32'd0);
        chk("rst_rsp_error", {31'b0, RSP_ERROR}, 32'd0);
        PRESET = 1'b0;
        #1;
        chk("post_rst_ready_low", {31'b0, CMD_READY}, 32'd0);
        @(negedge PCLK);
        chk("post_rst_ready_high", {31'b0, CMD_READY}, 32'd1);
        $display("reset sequence done");

        // Directed: write with PREADY immediately, read with 4 wait states,
        // write with completer error.
        xfer(1'b1, 32'h8, 32'h1234, 0, 32'h0, 1'b0, 1'b0);
        xfer(1'b0, 32'h4, 32'hCAFE_0001, 4, 32'hDEAD_BEEF, 1'b0, 1'b0);
        xfer(1'b1, 32'h0, 32'h0000_5A5A, 1, 32'h0, 1'b1, 1'b0);

        // Randomized transfers.
        for (int t = 0; t < 24; t++) begin
            r_wr    = 1'($urandom);
            r_addr  = $urandom & 32'hFFFF_FFFC;
            r_wdata = $urandom;
            r_rdata = $urandom;
            r_err   = ($urandom_range(0, 3) == 0);
            r_waits = $urandom_range(0, 4);
            xfer(r_wr, r_addr, r_wdata, r_waits, r_rdata, r_err, 1'b0);
        end

        // Back-to-back with CMD_VALID held high and PREADY tied high.
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;
        PRDATA    = 32'hA5A5_0001;
        CMD_VALID = 1'b1;
        CMD_WRITE = 1'b1;
        CMD_ADDR  = 32'h100;
        CMD_WDATA = 32'h11;
        n = 0;
        while (CMD_READY !== 1'b1 && n < 8) begin
            @(negedge PCLK);
            n++;
        end
        chk("b2b_ready1", {31'b0, CMD_READY}, 32'd1);
        acc1 = cyc;
        @(negedge PCLK);
        CMD_WRITE = 1'b0;
        CMD_ADDR  = 32'h104;
        CMD_WDATA = 32'h22;
        @(negedge PCLK);
        chk("b2b_access_paddr", PADDR, 32'h100);
        chk("b2b_access_pwdata", PWDATA, 32'h11);
        @(negedge PCLK);
        chk("b2b_rsp1_valid", {31'b0, RSP_VALID}, 32'd1);
        chk("b2b_rsp1_latency", cyc - acc1, 32'd3);
        chk("b2b_rsp1_rdata", RSP_RDATA, 32'h0);
        chk("b2b_gap_psel", {31'b0, PSELx}, 32'd0);
        chk("b2b_ready2", {31'b0, CMD_READY}, 32'd1);
        acc2 = cyc;
        @(negedge PCLK);
        CMD_VALID = 1'b0;
        chk("b2b_setup2_psel", {31'b0, PSELx}, 32'd1);
        chk("b2b_setup2_penable", {31'b0, PENABLE}, 32'd0);
        chk("b2b_setup2_paddr", PADDR, 32'h104);
        chk("b2b_setup2_pwrite", {31'b0, PWRITE}, 32'd0);
        @(negedge PCLK);
        @(negedge PCLK);
        chk("b2b_rsp2_valid", {31'b0, RSP_VALID}, 32'd1);
        chk("b2b_rsp2_latency", cyc - acc2, 32'd3);
        chk("b2b_rsp2_rdata", RSP_RDATA, 32'hA5A5_0001);
        PREADY = 1'b0;
        @(negedge PCLK);
        $display("back-to-back done");

        // Reset asserted during ACCESS aborts the transfer.
        CMD_VALID = 1'b1;
        CMD_WRITE = 1'b1;
        CMD_ADDR  = 32'h40;
        CMD_WDATA = 32'h77;
        n = 0;
        while (CMD_READY !== 1'b1 && n < 8) begin
            @(negedge PCLK);
            n++;
        end
        chk("rstmid_ready", {31'b0, CMD_READY}, 32'd1);
        @(negedge PCLK);
        CMD_VALID = 1'b0;
        @(negedge PCLK);
        chk("rstmid_in_access", {31'b0, PENABLE}, 32'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        PREADY = 1'b1;
        #1;
        chk("rstmid_psel", {31'b0, PSELx}, 32'd0);
        chk("rstmid_penable", {31'b0, PENABLE}, 32'd0);
        chk("rstmid_no_rsp", {31'b0, RSP_VALID}, 32'd0);
        chk("rstmid_ready_low", {31'b0, CMD_READY}, 32'd0);
        chk("rstmid_paddr", PADDR, 32'd0);
        @(negedge PCLK);
        chk("rstmid_ready_high", {31'b0, CMD_READY}, 32'd1);
        chk("rstmid_no_rsp2", {31'b0, RSP_VALID}, 32'd0);
        @(negedge PCLK);
        chk("rstmid_no_rsp3", {31'b0, RSP_VALID}, 32'd0);
        chk("rstmid_psel_idle", {31'b0, PSELx}, 32'd0);
        PREADY = 1'b0;
        $display("reset-in-access done");

`ifdef APB_TIMEOUT_EN
        // Completer never ready: abort after TMO ACCESS cycles.
        xfer(1'b0, 32'h20, 32'h0, 0, 32'h5555_5555, 1'b0, 1'b1);
        // PREADY in the limit cycle completes normally.
        xfer(1'b0, 32'h24, 32'h0, TMO - 1, 32'h7777_7777, 1'b0, 1'b0);
`endif

        // One more transfer to confirm recovery.
        xfer(1'b0, 32'hC, 32'h0, 2, 32'h0BAD_F00D, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
